// File: rtl/segment_r_ftab_rom.sv
// Host-loaded lookup table with a fixed-latency read pipeline and a credit-bounded skid FIFO on the output.
// Optional macro SEG_R_FTAB_PERF_EN adds the stall_cnt / tok_cnt performance counters.
module segment_r_ftab_rom #(
   parameter int AW   = 8,
   parameter int DW   = 64,
   parameter int LAT  = 2,
   parameter int SKID = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] ind_d,
   input  logic          ind_e,
   input  logic          ind_v,
   output logic          ind_b,
   output logic [DW-1:0] rdata_d,
   output logic          rdata_e,
   output logic          rdata_v,
   input  logic          rdata_b,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data
`ifdef SEG_R_FTAB_PERF_EN
   ,
   output logic [31:0]   stall_cnt,
   output logic [31:0]   tok_cnt
`endif
);

   localparam int DEPTH = 2 ** AW;
   localparam int PW    = (SKID > 1) ? $clog2(SKID) : 1;
   localparam int CW    = $clog2(SKID + 1);

   logic [DW-1:0] table_mem [DEPTH];
   logic [DW-1:0] pd [LAT];
   logic [LAT-1:0] pe;
   logic [LAT-1:0] pv;

   logic [DW-1:0] buf_d [SKID];
   logic [SKID-1:0] buf_e;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] buf_cnt;
   logic [CW-1:0] buf_cnt_next;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   logic fire_in;
   logic fire_out;
   logic push;

   always_comb begin
      fire_in  = ind_v & ~ind_b;
      fire_out = rdata_v & ~rdata_b;
      push     = pv[LAT-1];

      cnt_next = cnt;
      if (fire_in && !fire_out) begin
         cnt_next = cnt + CW'(1);
      end else if (fire_out && !fire_in) begin
         cnt_next = cnt - CW'(1);
      end

      buf_cnt_next = buf_cnt;
      if (push && !fire_out) begin
         buf_cnt_next = buf_cnt + CW'(1);
      end else if (fire_out && !push) begin
         buf_cnt_next = buf_cnt - CW'(1);
      end
   end

   assign rdata_v = (buf_cnt != '0);
   assign rdata_d = rdata_v ? buf_d[rd_ptr] : '0;
   assign rdata_e = rdata_v ? buf_e[rd_ptr] : 1'b0;

   // Storage without reset: the table survives reset, and data/flag lanes are
   // qualified by the valid bits, so stale contents never reach the output.
   // The table read registers the pre-write word, giving read-old on a same-cycle write.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         table_mem[wr_addr] <= wr_data;
      end
      pd[0] <= table_mem[ind_d];
      pe[0] <= ind_e;
      for (int i = 1; i < LAT; i++) begin
         pd[i] <= pd[i-1];
         pe[i] <= pe[i-1];
      end
      if (push) begin
         buf_d[wr_ptr] <= pd[LAT-1];
         buf_e[wr_ptr] <= pe[LAT-1];
      end
   end

   // The pipeline never stalls; the credit count guarantees a free buffer slot
   // for every token already inside it.
   always_ff @(posedge clock) begin
      if (reset) begin
         pv      <= '0;
         cnt     <= '0;
         buf_cnt <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ind_b   <= 1'b0;
      end else begin
         pv[0] <= fire_in;
         for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
         end
         cnt     <= cnt_next;
         buf_cnt <= buf_cnt_next;
         ind_b   <= (cnt_next == CW'(SKID));
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (fire_out) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

`ifdef SEG_R_FTAB_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         tok_cnt   <= '0;
      end else begin
         if (ind_v && ind_b && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (fire_out && (tok_cnt != '1)) begin
            tok_cnt <= tok_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_segment_r_ftab_rom.sv
// Directed and scoreboard bench for segment_r_ftab_rom (default parameters, LAT=2, SKID=4).
module tb_segment_r_ftab_rom;
   localparam int AW   = 8;
   localparam int DW   = 64;
   localparam int LAT  = 2;
   localparam int SKID = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] ind_d;
   logic          ind_e;
   logic          ind_v;
   logic          ind_b;
   logic [DW-1:0] rdata_d;
   logic          rdata_e;
   logic          rdata_v;
   logic          rdata_b;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
`ifdef SEG_R_FTAB_PERF_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   tok_cnt;
`endif

   segment_r_ftab_rom #(.AW(AW), .DW(DW), .LAT(LAT), .SKID(SKID)) dut (
      .clock   (clock),
      .reset   (reset),
      .ind_d   (ind_d),
      .ind_e   (ind_e),
      .ind_v   (ind_v),
      .ind_b   (ind_b),
      .rdata_d (rdata_d),
      .rdata_e (rdata_e),
      .rdata_v (rdata_v),
      .rdata_b (rdata_b),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
`ifdef SEG_R_FTAB_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .tok_cnt   (tok_cnt)
`endif
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] model [256];

   typedef struct {
      logic [7:0]  idx;
      logic        e;
      logic [63:0] d;
      logic        exp_e;
   } vec_t;
   vec_t vt[8];

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string nm, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] pat(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {8{b}};
   endfunction

   task automatic send_one(input logic [7:0] idx);
      ind_v = 1'b1; ind_d = idx; ind_e = 1'b0;
      tick;
      ind_v = 1'b0;
   endtask

   logic [64:0] q[$];
   logic [64:0] exp_tok;
   logic [63:0] prev_d;
   logic        prev_stall;
   logic        fi, fo;
   int acc, cyc, mcnt, n;

   initial begin
      vt[0] = '{8'd0,   1'b0, 64'h0000_0000_0000_0000, 1'b0};
      vt[1] = '{8'd1,   1'b0, 64'h0101_0101_0101_0101, 1'b0};
      vt[2] = '{8'd2,   1'b0, 64'h0202_0202_0202_0202, 1'b0};
      vt[3] = '{8'd255, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
      vt[4] = '{8'd128, 1'b0, 64'h8080_8080_8080_8080, 1'b0};
      vt[5] = '{8'd7,   1'b1, 64'h0707_0707_0707_0707, 1'b1};
      vt[6] = '{8'd66,  1'b0, 64'h4242_4242_4242_4242, 1'b0};
      vt[7] = '{8'd255, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

      reset = 1'b1; ind_v = 1'b0; ind_d = '0; ind_e = 1'b0; rdata_b = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      tick; tick;
      check("rst_v", rdata_v, 0);
      check("rst_d", rdata_d, 0);
      check("rst_e", rdata_e, 0);
      check("rst_b", ind_b, 0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat(i); model[i] = pat(i);
         tick;
      end
      wr_en = 1'b0;

      // back-to-back table vectors, outputs LAT+1 cycles after each accept
      for (int k = 0; k < 8 + LAT; k++) begin
         if (k < 8) begin
            ind_v = 1'b1; ind_d = vt[k].idx; ind_e = vt[k].e;
         end else begin
            ind_v = 1'b0;
         end
         tick;
         if (k >= LAT) begin
            check("vec_v", rdata_v, 1);
            check("vec_d", rdata_d, vt[k-LAT].d);
            check("vec_e", rdata_e, vt[k-LAT].exp_e);
         end else begin
            check("vec_lat", rdata_v, 0);
         end
      end
      tick;
      check("vec_idle", rdata_v, 0);

      // back-pressure fill and release
      rdata_b = 1'b1; n = 0;
      for (int k = 0; k < 10; k++) begin
         ind_v = 1'b1; ind_d = AW'(10 + n); ind_e = 1'b0;
         if (!ind_b) n++;
         tick;
         if (rdata_v) check("stall_hold", rdata_d, pat(10));
      end
      ind_v = 1'b0;
      check("fill_cnt", n, SKID);
      check("fill_b", ind_b, 1);
      rdata_b = 1'b0;
      for (int j = 0; j < 4; j++) begin
         check("drain_v", rdata_v, 1);
         check("drain_d", rdata_d, pat(10 + j));
         tick;
         if (j == 0) check("drain_b", ind_b, 0);
      end
      check("drain_empty", rdata_v, 0);

      // same-cycle write and read of address 7
      wr_en = 1'b1; wr_addr = 8'd7; wr_data = 64'hDEAD;
      ind_v = 1'b1; ind_d = 8'd7; ind_e = 1'b0;
      tick;
      wr_en = 1'b0; ind_v = 1'b0; model[7] = 64'hDEAD;
      tick; tick;
      check("rw_old", rdata_d, 64'h0707_0707_0707_0707);
      send_one(8'd7);
      tick; tick;
      check("rw_new", rdata_d, 64'hDEAD);
      tick;

      // random handshake against scoreboard
      acc = 0; cyc = 0; mcnt = 0; prev_stall = 1'b0; prev_d = '0;
      while ((acc < 10000 || q.size() != 0) && cyc < 80000) begin
         ind_v   = (acc < 10000) && ($urandom_range(0, 9) < 7);
         ind_d   = AW'($urandom);
         ind_e   = 1'($urandom);
         rdata_b = ($urandom_range(0, 9) < 3);
         if (prev_stall) check("rand_hold", rdata_d, prev_d);
         check("rand_credit", ind_b, (mcnt == SKID));
         fi = ind_v & ~ind_b;
         fo = rdata_v & ~rdata_b;
         if (fo) begin
            if (q.size() == 0) begin
               check("rand_spurious", 1, 0);
            end else begin
               exp_tok = q.pop_front();
               check("rand_data", {rdata_e, rdata_d}, exp_tok);
            end
         end
         if (fi) begin
            q.push_back({ind_e, model[ind_d]});
            acc++;
         end
         mcnt = mcnt + int'(fi) - int'(fo);
         prev_stall = rdata_v & rdata_b;
         prev_d = rdata_d;
         tick;
         cyc++;
      end
      check("rand_done", (acc == 10000 && q.size() == 0), 1);
      ind_v = 1'b0; rdata_b = 1'b0;
      tick; tick; tick;

      // reset with tokens in flight and buffered
      rdata_b = 1'b1;
      for (int k = 0; k < 4; k++) begin
         ind_v = 1'b1; ind_d = AW'(20 + k); ind_e = 1'b1;
         tick;
      end
      ind_v = 1'b0; reset = 1'b1;
      tick;
      check("mrst_v", rdata_v, 0);
      check("mrst_b", ind_b, 0);
      check("mrst_d", rdata_d, 0);
      reset = 1'b0; rdata_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick;
         check("mrst_drop", rdata_v, 0);
      end
      send_one(8'd200);
      tick; tick;
      check("mrst_tab200", rdata_d, 64'hC8C8_C8C8_C8C8_C8C8);
      send_one(8'd21);
      tick; tick;
      check("mrst_tab21", rdata_d, 64'h1515_1515_1515_1515);
      tick;

`ifdef SEG_R_FTAB_PERF_EN
      reset = 1'b1; tick; reset = 1'b0;
      rdata_b = 1'b1;
      for (int k = 0; k < 9; k++) begin
         ind_v = 1'b1; ind_d = AW'(k); ind_e = 1'b0;
         tick;
      end
      ind_v = 1'b0; rdata_b = 1'b0;
      for (int k = 0; k < 6; k++) tick;
      for (int k = 0; k < 8; k++) begin
         ind_v = 1'b1; ind_d = AW'(k); ind_e = 1'b0;
         tick;
      end
      ind_v = 1'b0;
      for (int k = 0; k < 6; k++) tick;
      check("perf_stall", stall_cnt, 5);
      check("perf_tok", tok_cnt, 12);
      reset = 1'b1; tick; reset = 1'b0;
      check("perf_rst_stall", stall_cnt, 0);
      check("perf_rst_tok", tok_cnt, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
